conv_mac_pipe: RTL and testbench

Parametrised successor to the fixed 3-lane convolution datapath. It computes a LANES-wide signed multiply-accumulate over a kernel window framed by valid/last, then scales it with a rounding, saturating arithmetic shift and optional ReLU. Results can optionally be max-pooled over a runtime-selectable run length. It sits between the image/kernel fetch logic and the result writer, and raises sticky accumulator and output saturation flags.

---
 rtl/conv_mac_pipe.sv | 159 +++++++++++++++
 tb/tb_conv_mac_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_pipe.sv
// LANES-wide signed MAC over valid/last-framed kernel windows, followed by a
// rounding saturating shift, optional ReLU and optional runtime-length max pooling.
module conv_mac_pipe #(
  parameter int LANES    = 3,
  parameter int PIX_W    = 8,
  parameter int ACC_W    = 20,
  parameter int OUT_W    = 8,
  parameter int SHFT_W   = 4,
  parameter int POOL_MAX = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic [LANES*PIX_W-1:0]              img_data,
  input  logic [LANES*PIX_W-1:0]              kern_data,
  input  logic [LANES-1:0]                    mask,
  input  logic [SHFT_W-1:0]                   shift,
  input  logic                                round_en,
  input  logic                                relu_en,
  input  logic                                pool_en,
  input  logic [$clog2(POOL_MAX+1)-1:0]       pool_len,
  input  logic                                pool_flush,
  input  logic                                flag_clr,
  output logic signed [OUT_W-1:0]             out_data,
  output logic                                out_valid,
  output logic                                acc_ovf,
  output logic                                out_sat
);

  localparam int PROD_W = 2 * PIX_W;
  localparam int SUM_W  = ACC_W + $clog2(LANES) + 1;
  localparam int RND_W  = ACC_W + 1;
  localparam int PL_W   = $clog2(POOL_MAX + 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (v > SUM_W'(ACC_MAX))      sat_acc = ACC_MAX;
    else if (v < SUM_W'(ACC_MIN)) sat_acc = ACC_MIN;
    else                          sat_acc = v[ACC_W-1:0];
  endfunction

  function automatic logic signed [RND_W-1:0] rnd_shift(input logic signed [ACC_W-1:0] a,
                                                        input logic [SHFT_W-1:0] sh,
                                                        input logic rnd);
    logic signed [RND_W-1:0] r;
    r = RND_W'(a);
    if (rnd && sh != '0) r = r + (RND_W'(1) << (sh - SHFT_W'(1)));
    rnd_shift = r >>> sh;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [RND_W-1:0] v);
    if (v > RND_W'(OUT_MAX))      sat_out = OUT_MAX;
    else if (v < RND_W'(OUT_MIN)) sat_out = OUT_MIN;
    else                          sat_out = v[OUT_W-1:0];
  endfunction

  logic signed [PROD_W-1:0] r_prod_p1 [LANES];
  logic                     r_vld_p1, r_last_p1;
  logic signed [ACC_W-1:0]  r_acc_p2;
  logic                     r_fresh_p2, r_done_p2;
  logic signed [OUT_W-1:0]  r_res_p3;
  logic                     r_vld_p3;
  logic [PL_W-1:0]          r_pool_cnt;
  logic signed [OUT_W-1:0]  r_pool_max;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_valid, r_acc_ovf, r_out_sat;

  logic signed [PROD_W-1:0] w_prod [LANES];
  logic signed [SUM_W-1:0]  w_sum;
  logic                     w_acc_ovf;
  logic signed [RND_W-1:0]  w_rnd;
  logic                     w_sat_out;
  logic signed [OUT_W-1:0]  w_res;
  logic                     w_pool_bypass, w_emit;
  logic [PL_W-1:0]          w_cnt_nxt;
  logic signed [OUT_W-1:0]  w_max_nxt;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = mask[i] ? PROD_W'($signed(img_data[i*PIX_W +: PIX_W])) *
                            PROD_W'($signed(kern_data[i*PIX_W +: PIX_W])) : '0;
    end
    // A fresh window starts from zero instead of the held accumulator
    w_sum = r_fresh_p2 ? '0 : SUM_W'(r_acc_p2);
    for (int i = 0; i < LANES; i++) w_sum = w_sum + SUM_W'(r_prod_p1[i]);
    w_acc_ovf = (w_sum > SUM_W'(ACC_MAX)) || (w_sum < SUM_W'(ACC_MIN));

    w_rnd     = rnd_shift(r_acc_p2, shift, round_en);
    w_sat_out = (w_rnd > RND_W'(OUT_MAX)) || (w_rnd < RND_W'(OUT_MIN));
    w_res     = sat_out(w_rnd);
    if (relu_en && w_res[OUT_W-1]) w_res = '0;

    w_pool_bypass = !pool_en || (pool_len <= PL_W'(1));
    w_cnt_nxt     = r_pool_cnt + PL_W'(r_vld_p3);
    w_max_nxt     = (r_vld_p3 && (r_pool_cnt == '0 || r_res_p3 > r_pool_max)) ? r_res_p3 : r_pool_max;
    w_emit        = (r_vld_p3 && w_cnt_nxt >= pool_len) || (pool_flush && w_cnt_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod_p1   <= '{default: '0};
      r_vld_p1    <= 1'b0;
      r_last_p1   <= 1'b0;
      r_acc_p2    <= '0;
      r_fresh_p2  <= 1'b1;
      r_done_p2   <= 1'b0;
      r_res_p3    <= '0;
      r_vld_p3    <= 1'b0;
      r_pool_cnt  <= '0;
      r_pool_max  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_acc_ovf   <= 1'b0;
      r_out_sat   <= 1'b0;
    end else begin
      // S1: masked lane products
      r_prod_p1 <= w_prod;
      r_vld_p1  <= in_valid;
      r_last_p1 <= in_valid && in_last;
      // S2: saturating accumulate
      if (r_vld_p1) begin
        r_acc_p2   <= sat_acc(w_sum);
        r_fresh_p2 <= r_last_p1;
      end
      r_done_p2 <= r_vld_p1 && r_last_p1;
      // S3: round, shift, saturate, ReLU
      r_vld_p3 <= r_done_p2;
      if (r_done_p2) r_res_p3 <= w_res;
      // S4: direct output or max pooling
      r_out_valid <= 1'b0;
      if (w_pool_bypass) begin
        if (r_vld_p3) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_res_p3;
        end
      end else if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_max_nxt;
        r_pool_cnt  <= '0;
      end else if (r_vld_p3) begin
        r_pool_cnt <= w_cnt_nxt;
        r_pool_max <= w_max_nxt;
      end
      r_acc_ovf <= (r_vld_p1 && w_acc_ovf) || (r_acc_ovf && !flag_clr);
      r_out_sat <= (r_done_p2 && w_sat_out) || (r_out_sat && !flag_clr);
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign acc_ovf   = r_acc_ovf;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Bench for conv_mac_pipe: window-level reference model with per-cycle output
// comparison, directed literal cases and randomized windows.
`timescale 1ns/1ps
module tb_conv_mac_pipe;

  logic              clk = 1'b0;
  logic              reset, in_valid, in_last;
  logic [23:0]       img_data, kern_data;
  logic [2:0]        mask;
  logic [3:0]        shift;
  logic              round_en, relu_en, pool_en, pool_flush, flag_clr;
  logic [2:0]        pool_len;
  logic signed [7:0] out_data;
  logic              out_valid, acc_ovf, out_sat;

  conv_mac_pipe #(.LANES(3), .PIX_W(8), .ACC_W(20), .OUT_W(8), .SHFT_W(4), .POOL_MAX(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .img_data(img_data), .kern_data(kern_data), .mask(mask), .shift(shift),
    .round_en(round_en), .relu_en(relu_en), .pool_en(pool_en), .pool_len(pool_len),
    .pool_flush(pool_flush), .flag_clr(flag_clr), .out_data(out_data),
    .out_valid(out_valid), .acc_ovf(acc_ovf), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;
  int n_str = 0, last_out = 0, last_cyc = 0;

  // Reference model state
  typedef struct { int arrive; int val; } pend_t;
  pend_t  pq[$];
  bit     ev[int];
  int     ed[int];
  longint m_acc = 0;
  bit     m_open = 0, m_ovf = 0, m_sat = 0;
  int     p_cnt = 0, p_max = 0;

  task automatic chk(input string nm, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  function automatic int scale(input longint acc);
    longint r;
    r = acc;
    if (round_en && shift != 0) r = r + (longint'(1) << (shift - 1));
    r = r >>> shift;
    if (r > 127) begin r = 127; m_sat = 1; end
    else if (r < -128) begin r = -128; m_sat = 1; end
    if (relu_en && r < 0) r = 0;
    return int'(r);
  endfunction

  // Advances the model by one cycle using the inputs currently driven.
  task automatic model_step(input int c);
    longint s;
    int     v;
    bit     have;
    if (reset) begin
      m_acc = 0; m_open = 0; pq.delete(); p_cnt = 0; p_max = 0; m_ovf = 0; m_sat = 0;
      return;
    end
    if (flag_clr) begin m_ovf = 0; m_sat = 0; end
    if (in_valid) begin
      s = m_open ? m_acc : 0;
      for (int i = 0; i < 3; i++)
        if (mask[i]) s += longint'($signed(img_data[i*8 +: 8])) * longint'($signed(kern_data[i*8 +: 8]));
      if (s > 524287) begin s = 524287; m_ovf = 1; end
      else if (s < -524288) begin s = -524288; m_ovf = 1; end
      m_acc  = s;
      m_open = !in_last;
      if (in_last) pq.push_back('{c + 3, scale(s)});
    end
    have = 0; v = 0;
    if (pq.size() > 0 && pq[0].arrive == c) begin
      v = pq[0].val;
      void'(pq.pop_front());
      have = 1;
    end
    if (!pool_en || pool_len <= 1) begin
      if (have) begin ev[c + 1] = 1; ed[c + 1] = v; end
    end else begin
      if (have) begin
        if (p_cnt == 0 || v > p_max) p_max = v;
        p_cnt++;
      end
      if ((have && p_cnt >= pool_len) || (pool_flush && p_cnt > 0)) begin
        ev[c + 1] = 1; ed[c + 1] = p_max; p_cnt = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    bit e;
    e = ev.exists(cyc) ? ev[cyc] : 1'b0;
    n_cmp++;
    if (out_valid !== e) begin
      n_fail++;
      $display("FAIL out_valid cyc=%0d: got %b, expected %b", cyc, out_valid, e);
    end else if (e) begin
      n_cmp++;
      if ($signed(out_data) != ed[cyc]) begin
        n_fail++;
        $display("FAIL out_data cyc=%0d: got %0d, expected %0d", cyc, $signed(out_data), ed[cyc]);
      end
    end
    if (out_valid === 1'b1) begin
      n_str++; last_out = $signed(out_data); last_cyc = cyc;
    end
  end

  task automatic step();
    model_step(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_last = 0; pool_flush = 0; flag_clr = 0; reset = 0;
    repeat (n) step();
  endtask

  task automatic beat(input logic [23:0] im, input logic [23:0] kn, input logic [2:0] m, input logic l);
    in_valid = 1; in_last = l; img_data = im; kern_data = kn; mask = m;
    step();
    in_valid = 0; in_last = 0;
  endtask

  task automatic set_cfg(input int sh, input bit rnd, input bit relu, input bit pen, input int plen);
    shift = 4'(sh); round_en = rnd; relu_en = relu; pool_en = pen; pool_len = 3'(plen);
  endtask

  task automatic clear_flags();
    flag_clr = 1; step(); flag_clr = 0; idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, tb, nb, gap;
    bit pen;
    reset = 1; in_valid = 0; in_last = 0; img_data = '0; kern_data = '0; mask = '0;
    flag_clr = 0; pool_flush = 0;
    set_cfg(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    step(); step();
    reset = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", acc_ovf, 0);
    chk("rst_sat", out_sat, 0);

    // 3 x (1*20) = 60, >>3 = 7 truncated, 8 rounded
    set_cfg(3, 0, 0, 0, 1);
    s0 = n_str; tb = cyc;
    beat({3{8'd1}}, {3{8'd20}}, 3'b111, 1); idle(6);
    chk("shift_trunc", last_out, 7);
    chk("latency", last_cyc - tb, 4);
    chk("one_strobe", n_str - s0, 1);
    set_cfg(3, 1, 0, 0, 1);
    beat({3{8'd1}}, {3{8'd20}}, 3'b111, 1); idle(6);
    chk("shift_round", last_out, 8);

    // -48768 saturates to -128; with ReLU to 0
    set_cfg(0, 0, 0, 0, 1);
    beat({3{8'h80}}, {3{8'h7F}}, 3'b111, 1); idle(6);
    chk("neg_sat", last_out, -128);
    chk("neg_sat_flag", out_sat, 1);
    chk("neg_no_ovf", acc_ovf, 0);
    set_cfg(0, 0, 1, 0, 1);
    beat({3{8'h80}}, {3{8'h7F}}, 3'b111, 1); idle(6);
    chk("relu", last_out, 0);
    chk("relu_sat_flag", out_sat, 1);
    clear_flags();
    chk("sat_cleared", out_sat, 0);

    // 11 x 49152 clamps at 524287; (524287+2048)>>12 = 128 -> 127
    set_cfg(12, 1, 0, 0, 1);
    repeat (10) beat({3{8'h80}}, {3{8'h80}}, 3'b111, 0);
    beat({3{8'h80}}, {3{8'h80}}, 3'b111, 1); idle(6);
    chk("acc_clamp_out", last_out, 127);
    chk("acc_ovf_flag", acc_ovf, 1);
    chk("acc_sat_flag", out_sat, 1);
    clear_flags();
    chk("ovf_cleared", acc_ovf, 0);
    chk("sat_cleared2", out_sat, 0);

    // Lane mask and back-to-back windows
    set_cfg(0, 0, 0, 0, 1);
    beat({8'd4, 8'd3, 8'd2}, {8'd7, 8'd6, 8'd5}, 3'b010, 1); idle(6);
    chk("mask_010", last_out, 18);
    s0 = n_str;
    repeat (2) begin
      beat({8'd4, 8'd3, 8'd2}, {8'd7, 8'd6, 8'd5}, 3'b010, 0);
      beat({8'd4, 8'd3, 8'd2}, {8'd7, 8'd6, 8'd5}, 3'b010, 1);
    end
    idle(6);
    chk("b2b_count", n_str - s0, 2);
    chk("b2b_value", last_out, 36);

    // Pooling: max of 5,-3,9,2; then partial run 4,6 flushed
    set_cfg(0, 0, 0, 1, 4);
    s0 = n_str;
    beat({16'd0, 8'd5}, {16'd0, 8'd1}, 3'b001, 1);
    beat({16'd0, 8'hFD}, {16'd0, 8'd1}, 3'b001, 1);
    beat({16'd0, 8'd9}, {16'd0, 8'd1}, 3'b001, 1);
    beat({16'd0, 8'd2}, {16'd0, 8'd1}, 3'b001, 1);
    idle(6);
    chk("pool_count", n_str - s0, 1);
    chk("pool_max", last_out, 9);
    beat({16'd0, 8'd4}, {16'd0, 8'd1}, 3'b001, 1);
    beat({16'd0, 8'd6}, {16'd0, 8'd1}, 3'b001, 1);
    idle(4);
    chk("pool_partial_held", n_str - s0, 1);
    pool_flush = 1; step(); pool_flush = 0; idle(2);
    chk("flush_count", n_str - s0, 2);
    chk("flush_max", last_out, 6);
    pool_flush = 1; step(); pool_flush = 0; idle(3);
    chk("empty_flush", n_str - s0, 2);

    // Reset mid-window discards the partial sum
    set_cfg(0, 0, 0, 0, 1);
    beat({3{8'd50}}, {3{8'd50}}, 3'b111, 0);
    beat({3{8'd50}}, {3{8'd50}}, 3'b111, 0);
    reset = 1; step(); reset = 0;
    s0 = n_str;
    beat({16'd0, 8'd10}, {16'd0, 8'd1}, 3'b001, 1); idle(6);
    chk("post_rst_count", n_str - s0, 1);
    chk("post_rst_value", last_out, 10);
    chk("post_rst_ovf", acc_ovf, 0);
    chk("post_rst_sat", out_sat, 0);

    // Randomized windows, model-checked every cycle
    for (int blk = 0; blk < 10; blk++) begin
      pen = $urandom_range(0, 1);
      set_cfg($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              pen, $urandom_range(1, 4));
      for (int w = 0; w < 15; w++) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          in_valid = 1; in_last = (b == nb - 1);
          img_data = $urandom; kern_data = $urandom; mask = 3'($urandom);
          pool_flush = pen && ($urandom_range(0, 5) == 0);
          step();
        end
        in_valid = 0; in_last = 0;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          pool_flush = pen && ($urandom_range(0, 5) == 0);
          step();
        end
      end
      idle(5);
      if (pen) begin pool_flush = 1; step(); pool_flush = 0; idle(2); end
      chk("rnd_acc_ovf", acc_ovf, longint'(m_ovf));
      chk("rnd_out_sat", out_sat, longint'(m_sat));
      clear_flags();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
